masked_share_decoder: RTL and testbench

MASKED_SHARE_DECODER -- requirements
Module: masked_share_decoder

---
 rtl/masked_share_decoder_pkg.sv | 17 +
 rtl/masked_share_decoder_share_fifo.sv | 51 +++++
 rtl/masked_share_decoder.sv | 92 +++++++++
 tb/tb_masked_share_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/masked_share_decoder_pkg.sv
// Shared types and constants for the masked share decoder.
// Holds the FSM encoding, the word counter width and its saturating increment.
package masked_share_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_CLR  = 2'd2
  } dec_state_e;

  localparam int unsigned WORD_COUNT_W = 16;

  function automatic logic [WORD_COUNT_W-1:0] sat_inc(input logic [WORD_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/masked_share_decoder_share_fifo.sv
// Result FIFO for decoded words: power-of-two depth, wrapping pointers.
// Pops on an empty FIFO are ignored; pushes on a full FIFO are ignored unless a pop frees a slot.
module share_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (occ_q != '0);
  assign do_push   = push && ((occ_q != CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr_q];
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/masked_share_decoder.sv
// Unmasks two-share words: shares are registered separately, XORed only from registers,
// and the result is queued in share_fifo. Share registers are scrubbed after every word.
//
// state   | meaning
// IDLE    | share registers zero, waiting for a share pair (if FIFO has room)
// HOLD    | shares held; XOR pushed into FIFO on the edge leaving this state
// CLR     | share registers zeroed on the edge leaving this state
module masked_share_decoder
  import masked_share_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_share0,
  input  logic [WIDTH-1:0]        in_share1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [WORD_COUNT_W-1:0] word_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  dec_state_e              state_q;
  dec_state_e              state_d;
  logic [WIDTH-1:0]        share0_q;
  logic [WIDTH-1:0]        share1_q;
  logic [CNT_W-1:0]        occupancy;
  logic                    in_xfer;
  logic                    push;
  logic [WORD_COUNT_W-1:0] word_count_q;
  logic [WORD_COUNT_W-1:0] word_count_d;

  // in_ready depends on registered state only, so out_ready never reaches it
  assign in_ready   = (state_q == ST_IDLE) && (occupancy != CNT_W'(DEPTH));
  assign in_xfer    = in_valid && in_ready;
  assign push       = (state_q == ST_HOLD);
  assign out_valid  = (occupancy != '0);
  assign word_count = word_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_xfer) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_CLR;
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_count_d = word_count_q;
    if (push) word_count_d = sat_inc(word_count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      share0_q     <= '0;
      share1_q     <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      if (in_xfer) begin
        share0_q <= in_share0;
        share1_q <= in_share1;
      end else if (state_q == ST_CLR) begin
        share0_q <= '0;
        share1_q <= '0;
      end
    end
  end

  share_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (share0_q ^ share1_q),
    .pop       (out_ready),
    .head_data (out_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_masked_share_decoder.sv
// Directed bench for masked_share_decoder (WIDTH=8, DEPTH=2) with a short random stream.
module tb_masked_share_decoder;
  import masked_share_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_share0;
  logic [7:0]  in_share1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] word_count;

  int vectors = 0;
  int miscompares = 0;

  masked_share_decoder #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_share0  (in_share0),
    .in_share1  (in_share1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair, waits (bounded) for acceptance, then runs through HOLD and CLR.
  task automatic send_word(input logic [7:0] s0, input logic [7:0] s1);
    int waited = 0;
    in_share0 = s0;
    in_share1 = s1;
    in_valid  = 1'b1;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) check("send_timeout", 32'd1, 32'd0);
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] cur_s0, cur_s1, exp_word;
  int tx, rx, cycles;
  bit saw_ff;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_share0 = '0; in_share1 = '0;
    step(); step();
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_out_data",  32'(out_data),   32'd0);
    check("rst_word_count",32'(word_count), 32'd0);
    rst_n = 1'b1;

    // single word, accepted on first edge after reset release
    in_valid = 1'b1; in_share0 = 8'hA5; in_share1 = 8'h0F; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sw_in_ready_hold", 32'(in_ready),  32'd0);
    check("sw_valid_early",   32'(out_valid), 32'd0);
    step();
    check("sw_out_valid", 32'(out_valid),  32'd1);
    check("sw_out_data",  32'(out_data),   32'hAA);
    check("sw_count",     32'(word_count), 32'd1);
    check("sw_in_ready_clr", 32'(in_ready), 32'd0);
    step();
    check("sw_share0_clr", 32'(dut.share0_q), 32'd0);
    check("sw_share1_clr", 32'(dut.share1_q), 32'd0);
    check("sw_popped",     32'(out_valid),    32'd0);
    check("sw_idle_ready", 32'(in_ready),     32'd1);

    // backpressure: third pair must wait for FIFO room
    out_ready = 1'b0;
    in_valid = 1'b1; in_share0 = 8'h01; in_share1 = 8'h00;
    step();
    in_share0 = 8'h02;
    step(); step();
    check("bp_ready_occ1", 32'(in_ready), 32'd1);
    check("bp_head1",      32'(out_data), 32'h01);
    step();
    in_share0 = 8'h03;
    step(); step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_occ2",       32'(dut.u_fifo.occupancy), 32'd2);
    step(); step();
    check("bp_still_blocked", 32'(in_ready), 32'd0);
    check("bp_head_stable",   32'(out_data), 32'h01);
    out_ready = 1'b1;
    step();
    check("bp_head2",       32'(out_data), 32'h02);
    check("bp_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);
    step();
    check("bp_head3_valid", 32'(out_valid), 32'd1);
    check("bp_head3",       32'(out_data),  32'h03);
    step();
    check("bp_count", 32'(word_count), 32'd4);

    // push and pop on the same edge with one word queued
    out_ready = 1'b0;
    send_word(8'h12, 8'h34);
    check("pp_pre_head", 32'(out_data), 32'h26);
    in_valid = 1'b1; in_share0 = 8'h55; in_share1 = 8'hAA;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("pp_occ",   32'(dut.u_fifo.occupancy), 32'd1);
    check("pp_head",  32'(out_data),  32'hFF);
    check("pp_valid", 32'(out_valid), 32'd1);
    step();
    check("pp_drained", 32'(out_valid), 32'd0);
    check("pp_count",   32'(word_count), 32'd6);

    // reset while in HOLD discards the word
    in_valid = 1'b1; in_share0 = 8'hFF; in_share1 = 8'h00;
    step();
    in_valid = 1'b0;
    check("rh_in_hold", 32'(dut.state_q), 32'(ST_HOLD));
    rst_n = 1'b0;
    #2;
    check("rh_valid", 32'(out_valid),  32'd0);
    check("rh_count", 32'(word_count), 32'd0);
    step();
    rst_n = 1'b1;
    saw_ff = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) saw_ff = 1'b1;
    end
    check("rh_no_emit",  32'(saw_ff),     32'd0);
    check("rh_count_after", 32'(word_count), 32'd0);

    // saturation: preload near the top, then push past it
    force dut.word_count_q = 16'hFFFD;
    step();
    release dut.word_count_q;
    #1;
    check("sat_preload", 32'(word_count), 32'hFFFD);
    send_word(8'h01, 8'h02);
    check("sat_fffe", 32'(word_count), 32'hFFFE);
    send_word(8'h03, 8'h04);
    check("sat_ffff", 32'(word_count), 32'hFFFF);
    send_word(8'h05, 8'h06);
    check("sat_hold", 32'(word_count), 32'hFFFF);

    // random streaming with random backpressure
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    tx = 0; rx = 0; cycles = 0;
    cur_s0 = 8'($urandom); cur_s1 = 8'($urandom);
    while (rx < 1000 && cycles < 20000) begin
      in_valid  = (tx < 1000) && ($urandom_range(0, 3) != 0);
      in_share0 = cur_s0;
      in_share1 = cur_s1;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready && dut.state_q != ST_IDLE) check("rnd_ready_state", 32'd1, 32'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_s0 ^ cur_s1);
        tx++;
        cur_s0 = 8'($urandom); cur_s1 = 8'($urandom);
      end
      if (out_valid && out_ready) begin
        exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        check("rnd_out_data", 32'(out_data), 32'(exp_word));
        rx++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check("rnd_all_received", 32'(rx), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
